// File: rtl/id_stage.sv
// Instruction-decode stage: control decode, 32x32 register file with WB write-through,
// immediate sign extension, and the ID/EX pipeline register.
module id_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   IF_ID_PC,
  input  logic [31:0]       IF_ID_Instruction,
  input  logic              RegWrite,
  input  logic [REG_AW-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] ID_EX_ReadData1,
  output logic [DATA_W-1:0] ID_EX_ReadData2,
  output logic [DATA_W-1:0] ID_EX_SignExtImm,
  output logic [REG_AW-1:0] ID_EX_Rb,
  output logic [REG_AW-1:0] ID_EX_Rt,
  output logic [REG_AW-1:0] ID_EX_Rd,
  output logic [PC_W-1:0]   ID_EX_PC,
  output logic              ID_EX_RegDst,
  output logic              ID_EX_ALUSrc,
  output logic              ID_EX_MemToReg,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_Branch,
  output logic [1:0]        ID_EX_ALUOp
);

  localparam int NUM_REGS = 2 ** REG_AW;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [15:0]       imm;
  logic [DATA_W-1:0] sign_ext_imm;
  logic [DATA_W-1:0] read_data1, read_data2;
  logic              wb_en;
  ctrl_t             ctrl, ctrl_q;

  logic [DATA_W-1:0] regs [NUM_REGS];

  assign opcode       = IF_ID_Instruction[31:26];
  assign rs           = IF_ID_Instruction[25:21];
  assign rt           = IF_ID_Instruction[20:16];
  assign rd           = IF_ID_Instruction[15:11];
  assign imm          = IF_ID_Instruction[15:0];
  assign sign_ext_imm = {{(DATA_W-16){imm[15]}}, imm};

  always_comb begin
    // NOTE: default every output first so unlisted opcodes cannot infer a latch.
    ctrl = '0;
    case (opcode_e'(opcode))
      OP_RTYPE: ctrl = '{reg_dst: 1'b1, alu_src: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b1,
                         mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0, alu_op: 2'b10};
      OP_LW:    ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b1, reg_write: 1'b1,
                         mem_read: 1'b1, mem_write: 1'b0, branch: 1'b0, alu_op: 2'b00};
      OP_SW:    ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0, reg_write: 1'b0,
                         mem_read: 1'b0, mem_write: 1'b1, branch: 1'b0, alu_op: 2'b00};
      OP_BEQ:   ctrl = '{reg_dst: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0,
                         mem_read: 1'b0, mem_write: 1'b0, branch: 1'b1, alu_op: 2'b01};
      OP_ADDI:  ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0, reg_write: 1'b1,
                         mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0, alu_op: 2'b00};
      default:  ctrl = '0;
    endcase
  end

  // r0 is hard-wired to zero, so it never takes a write or a bypass.
  assign wb_en = RegWrite && (writeReg != '0);

  assign read_data1 = (rs == '0)                 ? '0 :
                      (wb_en && writeReg == rs)  ? writeData : regs[rs];
  assign read_data2 = (rt == '0)                 ? '0 :
                      (wb_en && writeReg == rt)  ? writeData : regs[rt];

  // NOTE: this register file is cleared on reset because the architecture requires it;
  // an ordinary RAM would not be reset and could then map onto memory macros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[writeReg] <= writeData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID_EX_ReadData1  <= '0;
      ID_EX_ReadData2  <= '0;
      ID_EX_SignExtImm <= '0;
      ID_EX_Rb         <= '0;
      ID_EX_Rt         <= '0;
      ID_EX_Rd         <= '0;
      ID_EX_PC         <= '0;
      ctrl_q           <= '0;
    end else begin
      ID_EX_ReadData1  <= read_data1;
      ID_EX_ReadData2  <= read_data2;
      ID_EX_SignExtImm <= sign_ext_imm;
      ID_EX_Rb         <= rs;
      ID_EX_Rt         <= rt;
      ID_EX_Rd         <= rd;
      ID_EX_PC         <= IF_ID_PC;
      ctrl_q           <= ctrl;
    end
  end

  assign ID_EX_RegDst   = ctrl_q.reg_dst;
  assign ID_EX_ALUSrc   = ctrl_q.alu_src;
  assign ID_EX_MemToReg = ctrl_q.mem_to_reg;
  assign ID_EX_RegWrite = ctrl_q.reg_write;
  assign ID_EX_MemRead  = ctrl_q.mem_read;
  assign ID_EX_MemWrite = ctrl_q.mem_write;
  assign ID_EX_Branch   = ctrl_q.branch;
  assign ID_EX_ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: table-driven vectors feed a scoreboard queue,
// plus hand-written reset sequences (initial reset and asynchronous mid-run reset).
module tb_id_stage;

  localparam int DATA_W = 32;
  localparam int PC_W   = 8;
  localparam int REG_AW = 5;

  // Control packing: {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}
  localparam logic [8:0] C_R    = 9'b1_0_0_1_0_0_0_10;
  localparam logic [8:0] C_LW   = 9'b0_1_1_1_1_0_0_00;
  localparam logic [8:0] C_SW   = 9'b0_1_0_0_0_1_0_00;
  localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_1_01;
  localparam logic [8:0] C_ADDI = 9'b0_1_0_1_0_0_0_00;
  localparam logic [8:0] C_NONE = 9'b0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [7:0]  pc;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [8:0]  ctrl;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rb, rt, rd;
    logic [7:0]  pc;
    logic [8:0]  ctrl;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [PC_W-1:0]   IF_ID_PC;
  logic [31:0]       IF_ID_Instruction;
  logic              RegWrite;
  logic [REG_AW-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm;
  logic [REG_AW-1:0] ID_EX_Rb, ID_EX_Rt, ID_EX_Rd;
  logic [PC_W-1:0]   ID_EX_PC;
  logic              ID_EX_RegDst, ID_EX_ALUSrc, ID_EX_MemToReg, ID_EX_RegWrite;
  logic              ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch;
  logic [1:0]        ID_EX_ALUOp;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t vecs[14];

  id_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .IF_ID_PC          (IF_ID_PC),
    .IF_ID_Instruction (IF_ID_Instruction),
    .RegWrite          (RegWrite),
    .writeReg          (writeReg),
    .writeData         (writeData),
    .ID_EX_ReadData1   (ID_EX_ReadData1),
    .ID_EX_ReadData2   (ID_EX_ReadData2),
    .ID_EX_SignExtImm  (ID_EX_SignExtImm),
    .ID_EX_Rb          (ID_EX_Rb),
    .ID_EX_Rt          (ID_EX_Rt),
    .ID_EX_Rd          (ID_EX_Rd),
    .ID_EX_PC          (ID_EX_PC),
    .ID_EX_RegDst      (ID_EX_RegDst),
    .ID_EX_ALUSrc      (ID_EX_ALUSrc),
    .ID_EX_MemToReg    (ID_EX_MemToReg),
    .ID_EX_RegWrite    (ID_EX_RegWrite),
    .ID_EX_MemRead     (ID_EX_MemRead),
    .ID_EX_MemWrite    (ID_EX_MemWrite),
    .ID_EX_Branch      (ID_EX_Branch),
    .ID_EX_ALUOp       (ID_EX_ALUOp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] instr, input logic [7:0] pc,
                              input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic [8:0] ctrl);
    vec_t v;
    v.name = name; v.instr = instr; v.pc = pc; v.we = we; v.wreg = wreg; v.wdata = wdata;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.ctrl = ctrl;
    return v;
  endfunction

  function automatic exp_t zero_exp(input string name);
    exp_t e;
    e.name = name; e.rd1 = '0; e.rd2 = '0; e.imm = '0;
    e.rb = '0; e.rt = '0; e.rd = '0; e.pc = '0; e.ctrl = '0;
    return e;
  endfunction

  // Drive a vector's inputs and push what ID/EX must hold after the next edge.
  task automatic drive_vec(input vec_t v);
    exp_t e;
    IF_ID_Instruction = v.instr;
    IF_ID_PC          = v.pc;
    RegWrite          = v.we;
    writeReg          = v.wreg;
    writeData         = v.wdata;
    e.name = v.name; e.rd1 = v.rd1; e.rd2 = v.rd2; e.imm = v.imm;
    e.rb = v.instr[25:21]; e.rt = v.instr[20:16]; e.rd = v.instr[15:11];
    e.pc = v.pc; e.ctrl = v.ctrl;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected a pending entry");
      return;
    end
    n_checks--;
    e = sb.pop_front();
    check({e.name, ".rd1"}, ID_EX_ReadData1, e.rd1);
    check({e.name, ".rd2"}, ID_EX_ReadData2, e.rd2);
    check({e.name, ".imm"}, ID_EX_SignExtImm, e.imm);
    check({e.name, ".rb"},  32'(ID_EX_Rb), 32'(e.rb));
    check({e.name, ".rt"},  32'(ID_EX_Rt), 32'(e.rt));
    check({e.name, ".rd"},  32'(ID_EX_Rd), 32'(e.rd));
    check({e.name, ".pc"},  32'(ID_EX_PC), 32'(e.pc));
    check({e.name, ".ctrl"},
          32'({ID_EX_RegDst, ID_EX_ALUSrc, ID_EX_MemToReg, ID_EX_RegWrite,
               ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch, ID_EX_ALUOp}),
          32'(e.ctrl));
  endtask

  initial begin
    // Register file contents implied by the sequence: r1=0x10 then 0xDEADBEEF,
    // r3=0xCAFEF00D, r31=0x55AA55AA; r0 write of all-ones is dropped.
    vecs[0]  = mk("read_r5",   32'h8CA60000, 8'd4,   1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        C_LW);
    vecs[1]  = mk("wb_r1",     32'h00000000, 8'd0,   1'b1, 5'd1,  32'h00000010, 32'h0,        32'h0,        32'h0,        C_R);
    vecs[2]  = mk("lw_decode", 32'h8C220004, 8'd8,   1'b0, 5'd0,  32'h0,        32'h00000010, 32'h0,        32'h00000004, C_LW);
    vecs[3]  = mk("neg_imm",   32'h8C22FFFC, 8'd12,  1'b0, 5'd0,  32'h0,        32'h00000010, 32'h0,        32'hFFFFFFFC, C_LW);
    vecs[4]  = mk("bypass_rs", 32'h8C220004, 8'd16,  1'b1, 5'd1,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h00000004, C_LW);
    vecs[5]  = mk("wr_r0",     32'h00000000, 8'd20,  1'b1, 5'd0,  32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        C_R);
    vecs[6]  = mk("rd_r0_byp", 32'h20030007, 8'd24,  1'b1, 5'd3,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h00000007, C_ADDI);
    vecs[7]  = mk("rtype",     32'h00232020, 8'd28,  1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 32'hCAFEF00D, 32'h00002020, C_R);
    vecs[8]  = mk("sw",        32'hAC618000, 8'd32,  1'b0, 5'd0,  32'h0,        32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFF8000, C_SW);
    vecs[9]  = mk("beq",       32'h1021FFFE, 8'd36,  1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFE, C_BEQ);
    vecs[10] = mk("addi",      32'h20657FFF, 8'd40,  1'b0, 5'd0,  32'h0,        32'hCAFEF00D, 32'h0,        32'h00007FFF, C_ADDI);
    vecs[11] = mk("unknown",   32'hFC231234, 8'd44,  1'b1, 5'd31, 32'h55AA55AA, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00001234, C_NONE);
    vecs[12] = mk("read_r31",  32'h8FE00000, 8'd255, 1'b0, 5'd0,  32'h0,        32'h55AA55AA, 32'h0,        32'h0,        C_LW);
    vecs[13] = mk("post_rst",  32'h8C3F0000, 8'd3,   1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        C_LW);

    // Reset held across two edges with a live instruction and an active WB write to r5.
    rst = 1'b1;
    IF_ID_Instruction = 32'h8CA50004;
    IF_ID_PC          = 8'h3C;
    RegWrite          = 1'b1;
    writeReg          = 5'd5;
    writeData         = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(zero_exp($sformatf("reset_edge%0d", i)));
      @(posedge clk); #1;
      compare_out();
    end

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      drive_vec(vecs[i]);
      @(posedge clk); #1;
      compare_out();
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle: outputs clear with no clock edge.
    drive_vec(vecs[7]);
    rst = 1'b1;
    void'(sb.pop_front());
    sb.push_back(zero_exp("async_rst"));
    #1;
    compare_out();
    sb.push_back(zero_exp("async_rst_edge"));
    @(posedge clk); #1;
    compare_out();

    // Registers r1 and r31 were cleared by that reset.
    @(negedge clk);
    rst = 1'b0;
    drive_vec(vecs[13]);
    @(posedge clk); #1;
    compare_out();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
